// File: rtl/adc_in.sv
`default_nettype none
// ============================================================================
// Module      : adc_in
// Description : Windowed ADC averager converting two's-complement ADC codes
//               into a signed Q16.48 voltage word, VOLTAGE = -avg * 20/16384.
//               Window of 2^AVG_LOG2_IN samples, three-stage result pipeline.
//               Optional macro ADC_IN_OVERRANGE_EN enables the per-window
//               clipped-sample flag on OVERRANGE_OUT.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_in #(
  parameter int FLOAT_WIDTH = 64,
  parameter int ADC_WIDTH   = 14,
  parameter int FRAC_BITS   = 48
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [ADC_WIDTH-1:0]   ADC_CODE_IN,
  input  logic                   ADC_VALID_IN,
  input  logic [2:0]             AVG_LOG2_IN,
  output logic [FLOAT_WIDTH-1:0] VOLTAGE_OUT,
  output logic                   VOLTAGE_VALID_OUT,
  output logic                   OVERRANGE_OUT
);

  // Accumulator holds up to 128 full-scale codes without overflow.
  localparam int c_ACC_W  = ADC_WIDTH + 7;
  // Room for the x5 scaling of the average.
  localparam int c_PROD_W = c_ACC_W + 3;
  // 20/2^ADC_WIDTH = 5 * 2^-(ADC_WIDTH-2); the rest is the Q-format alignment.
  localparam int c_SHIFT  = FRAC_BITS - (ADC_WIDTH - 2);
  localparam int c_EXT_W  = FLOAT_WIDTH - c_PROD_W;

  logic signed [c_ACC_W-1:0]  r_acc;
  logic [7:0]                 r_cnt;
  logic [2:0]                 r_n_lat;

  logic                       w_first;
  logic [2:0]                 w_n_eff;
  logic [7:0]                 w_win_len;
  logic                       w_close;
  logic signed [c_ACC_W-1:0]  w_code_ext;
  logic signed [c_ACC_W-1:0]  w_sum;
  logic signed [c_ACC_W-1:0]  w_avg;

  logic                       r_s1_vld;
  logic signed [c_ACC_W-1:0]  r_s1_avg;
  logic                       r_s2_vld;
  logic signed [c_PROD_W-1:0] r_s2_prod;
  logic signed [c_PROD_W-1:0] w_avg_ext;
  logic signed [c_PROD_W-1:0] w_neg5;
  logic [FLOAT_WIDTH-1:0]     w_vout_next;
  logic [FLOAT_WIDTH-1:0]     r_vout;
  logic                       r_vout_vld;

  // A window starts whenever the sample counter is empty; the size select is
  // taken live for the first sample and from the latch afterwards.
  assign w_first    = (r_cnt == 8'd0);
  assign w_n_eff    = w_first ? AVG_LOG2_IN : r_n_lat;
  assign w_win_len  = 8'd1 << w_n_eff;
  assign w_close    = ADC_VALID_IN && ((r_cnt + 8'd1) == w_win_len);
  assign w_code_ext = {{(c_ACC_W-ADC_WIDTH){ADC_CODE_IN[ADC_WIDTH-1]}}, ADC_CODE_IN};
  assign w_sum      = r_acc + w_code_ext;
  // Averaging includes the closing sample, so shift the running sum directly.
  assign w_avg      = w_sum >>> w_n_eff;

  // Accumulate accepted samples; clear on the closing sample so the next
  // cycle's sample starts a fresh window.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_acc   <= '0;
      r_cnt   <= 8'd0;
      r_n_lat <= 3'd0;
    end else if (ADC_VALID_IN) begin
      if (w_first) begin
        r_n_lat <= AVG_LOG2_IN;
      end
      if (w_close) begin
        r_acc <= '0;
        r_cnt <= 8'd0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // Stage 1: capture the floored average of the closed window.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1_vld <= 1'b0;
      r_s1_avg <= '0;
    end else begin
      r_s1_vld <= w_close;
      if (w_close) begin
        r_s1_avg <= w_avg;
      end
    end
  end

  assign w_avg_ext = {{(c_PROD_W-c_ACC_W){r_s1_avg[c_ACC_W-1]}}, r_s1_avg};
  assign w_neg5    = -((w_avg_ext <<< 2) + w_avg_ext);

  // Stage 2: scale by -5 (exact integer product).
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s2_vld  <= 1'b0;
      r_s2_prod <= '0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_prod <= w_neg5;
      end
    end
  end

  assign w_vout_next = {{c_EXT_W{r_s2_prod[c_PROD_W-1]}}, r_s2_prod} << c_SHIFT;

  // Stage 3: align to Q16.48 and hold until the next result.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vout     <= '0;
      r_vout_vld <= 1'b0;
    end else begin
      r_vout_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_vout <= w_vout_next;
      end
    end
  end

  assign VOLTAGE_OUT       = r_vout;
  assign VOLTAGE_VALID_OUT = r_vout_vld;

`ifdef ADC_IN_OVERRANGE_EN
  logic r_ovr_acc;
  logic r_s1_ovr;
  logic r_s2_ovr;
  logic r_ovr_out;
  logic w_ovr_smp;
  logic w_ovr_win;

  // A sample at either rail is treated as clipped.
  assign w_ovr_smp = (ADC_CODE_IN == {1'b1, {(ADC_WIDTH-1){1'b0}}}) ||
                     (ADC_CODE_IN == {1'b0, {(ADC_WIDTH-1){1'b1}}});
  assign w_ovr_win = r_ovr_acc | w_ovr_smp;

  // Collect the window flag and carry it alongside the result pipeline.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ovr_acc <= 1'b0;
      r_s1_ovr  <= 1'b0;
      r_s2_ovr  <= 1'b0;
      r_ovr_out <= 1'b0;
    end else begin
      if (ADC_VALID_IN) begin
        r_ovr_acc <= w_close ? 1'b0 : w_ovr_win;
      end
      if (w_close) begin
        r_s1_ovr <= w_ovr_win;
      end
      if (r_s1_vld) begin
        r_s2_ovr <= r_s1_ovr;
      end
      if (r_s2_vld) begin
        r_ovr_out <= r_s2_ovr;
      end
    end
  end

  assign OVERRANGE_OUT = r_ovr_out;
`else
  assign OVERRANGE_OUT = 1'b0;
`endif

endmodule
`default_nettype wire
